buzz_sequencer: RTL and testbench

- Arbitrates the single piezo buzzer between three requesters: the core FSM's match, end-of-track and no-colour-error events.
- Plays a distinct beep pattern for each requester and returns a one-cycle completion pulse to it.
- Sits between the core FSM (level requests, waits for finished) and the buzzer pin, and generates the tone square wave itself.

---
 rtl/buzz_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_buzz_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/buzz_sequencer.sv
// rtl/buzz_sequencer.sv - piezo buzzer arbiter and beep pattern generator
//
// Shares one buzzer between three level requesters and plays a distinct
// beep pattern for each, generating the tone square wave internally.
//   match        : 1 beep x 4 units
//   end-of-track : 2 beeps x 2 units
//   error        : 3 beeps x 1 unit
// Beeps are separated by a 1-unit silent gap; there is no trailing gap.
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   req_i    level requests: [0] match, [1] end-of-track, [2] error
//   grant_o  one-hot owner of the buzzer
//   done_o   one-cycle pulse on the granted bit when its pattern completes
//   busy_o   high whenever the sequencer is not idle
//   buzz_o   buzzer drive, square wave during beeps, 0 otherwise
module buzz_sequencer #(
    parameter int CLK_FREQ = 50000000,
    parameter int TONE_HZ  = 2000,
    parameter int UNIT_MS  = 100
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    output logic [2:0] grant_o,
    output logic [2:0] done_o,
    output logic       busy_o,
    output logic       buzz_o
);

    localparam int HALF     = CLK_FREQ / (2 * TONE_HZ);
    localparam int UNIT_CYC = CLK_FREQ / 1000 * UNIT_MS;
    localparam int UW       = $clog2(4 * UNIT_CYC);
    // A one-cycle half period still needs a 1-bit counter to exist.
    localparam int TW       = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TONE,
        S_GAP,
        S_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [2:0]     done_q,  done_d;
    logic           busy_q,  busy_d;
    logic           buzz_q,  buzz_d;
    logic [UW-1:0]  unit_q,  unit_d;
    logic [TW-1:0]  tone_q,  tone_d;
    logic [1:0]     beep_q,  beep_d;

    logic [UW-1:0]  tone_last;
    logic [1:0]     beep_last;
    logic           owner_req;

    // Pattern shape of the current owner: last unit-counter value of a
    // beep and index of the final beep.
    always_comb begin
        tone_last = UW'(4 * UNIT_CYC - 1);
        beep_last = 2'd0;
        if (grant_q[2]) begin
            tone_last = UW'(UNIT_CYC - 1);
            beep_last = 2'd2;
        end else if (grant_q[1]) begin
            tone_last = UW'(2 * UNIT_CYC - 1);
            beep_last = 2'd1;
        end
    end

    assign owner_req = |(req_i & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 3'b000;
        busy_d  = busy_q;
        buzz_d  = buzz_q;
        unit_d  = unit_q;
        tone_d  = tone_q;
        beep_d  = beep_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    if (req_i[2])      grant_d = 3'b100;
                    else if (req_i[1]) grant_d = 3'b010;
                    else               grant_d = 3'b001;
                    state_d = S_TONE;
                    busy_d  = 1'b1;
                    buzz_d  = 1'b1;
                    unit_d  = '0;
                    tone_d  = '0;
                    beep_d  = '0;
                end
            end

            S_TONE: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (unit_q == tone_last) begin
                    unit_d = '0;
                    tone_d = '0;
                    buzz_d = 1'b0;
                    if (beep_q != beep_last) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_HOLD;
                        done_d  = grant_q;
                    end
                end else begin
                    unit_d = unit_q + UW'(1);
                    if (tone_q == TW'(HALF - 1)) begin
                        tone_d = '0;
                        buzz_d = ~buzz_q;
                    end else begin
                        tone_d = tone_q + TW'(1);
                    end
                end
            end

            S_GAP: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (unit_q == UW'(UNIT_CYC - 1)) begin
                    state_d = S_TONE;
                    unit_d  = '0;
                    tone_d  = '0;
                    buzz_d  = 1'b1;
                    beep_d  = beep_q + 2'd1;
                end else begin
                    unit_d = unit_q + UW'(1);
                end
            end

            S_HOLD: begin
                // Waiting for the owner to drop its request, so a held
                // request cannot retrigger the pattern.
                if (!owner_req) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Any return to idle (completion or abort) releases everything.
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            grant_d = 3'b000;
            busy_d  = 1'b0;
            buzz_d  = 1'b0;
            unit_d  = '0;
            tone_d  = '0;
            beep_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            done_q  <= 3'b000;
            busy_q  <= 1'b0;
            buzz_q  <= 1'b0;
            unit_q  <= '0;
            tone_q  <= '0;
            beep_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            buzz_q  <= buzz_d;
            unit_q  <= unit_d;
            tone_q  <= tone_d;
            beep_q  <= beep_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign buzz_o  = buzz_q;

endmodule

// File: tb/tb_buzz_sequencer.sv
// tb/tb_buzz_sequencer.sv - scoreboard bench for buzz_sequencer
module tb_buzz_sequencer;

    logic       clk;
    logic       rst_ni;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic       buzz;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] grant;
        logic [2:0] done;
        logic       busy;
        logic       buzz;
    } exp_t;

    exp_t q[$];

    buzz_sequencer #(
        .CLK_FREQ(1000),
        .TONE_HZ (100),
        .UNIT_MS (10)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .req_i  (req),
        .grant_o(grant),
        .done_o (done),
        .busy_o (busy),
        .buzz_o (buzz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] g, input logic [2:0] d,
                        input logic b, input logic z);
        exp_t e;
        e.cyc = c; e.grant = g; e.done = d; e.busy = b; e.buzz = z;
        q.push_back(e);
    endtask

    task automatic zeros(input int a, input int b);
        for (int c = a; c <= b; c++) push(c, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic exp_hold(input int a, input int b, input logic [2:0] g);
        for (int c = a; c <= b; c++) push(c, g, 3'b000, 1'b1, 1'b0);
    endtask

    // Tone starts high and toggles every 5 cycles.
    task automatic exp_tone(input int a, input logic [2:0] g, input int n);
        for (int k = 0; k < n; k++) push(a + k, g, 3'b000, 1'b1, ((k / 5) % 2) == 0);
    endtask

    task automatic exp_pat(input int g0, input logic [2:0] g, input int len,
                           input int n, output int dcyc);
        int off;
        off = 0;
        for (int b = 0; b < n; b++) begin
            exp_tone(g0 + off, g, len * 10);
            off += len * 10;
            if (b < n - 1) begin
                exp_hold(g0 + off, g0 + off + 9, g);
                off += 10;
            end
        end
        push(g0 + off, g, g, 1'b1, 1'b0);
        dcyc = g0 + off;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares the DUT outputs against the scoreboard each cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d expected entry for cyc %0d never compared", cyc, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if ({grant, done, busy, buzz} !== {e.grant, e.done, e.busy, e.buzz}) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d grant/done/busy/buzz got %b/%b/%b/%b want %b/%b/%b/%b",
                             cyc, grant, done, busy, buzz, e.grant, e.done, e.busy, e.buzz);
                end
            end
        end
    end

    initial begin
        int c, d, d2;
        rst_ni = 1'b0;
        req    = 3'b000;

        zeros(1, 5);
        wait_cyc(3);
        rst_ni = 1'b1;
        wait_cyc(5);

        // Single match, held a few cycles past done.
        c = cyc;
        req = 3'b001;
        exp_pat(c + 1, 3'b001, 4, 1, d);
        exp_hold(d + 1, d + 5, 3'b001);
        zeros(d + 6, d + 8);
        wait_cyc(d + 5);
        req = 3'b000;
        wait_cyc(d + 8);

        // Error pattern.
        c = cyc;
        req = 3'b100;
        exp_pat(c + 1, 3'b100, 1, 3, d);
        zeros(d + 1, d + 3);
        wait_cyc(d);
        req = 3'b000;
        wait_cyc(d + 3);

        // Simultaneous requests: error wins, then end-of-track after one idle cycle.
        c = cyc;
        req = 3'b111;
        exp_pat(c + 1, 3'b100, 1, 3, d);
        zeros(d + 1, d + 1);
        exp_pat(d + 2, 3'b010, 2, 2, d2);
        zeros(d2 + 1, d2 + 3);
        wait_cyc(d);
        req = 3'b011;
        wait_cyc(d2);
        req = 3'b000;
        wait_cyc(d2 + 3);

        // Abort during the gap.
        c = cyc;
        req = 3'b010;
        exp_tone(c + 1, 3'b010, 20);
        exp_hold(c + 21, c + 25, 3'b010);
        zeros(c + 26, c + 40);
        wait_cyc(c + 25);
        req = 3'b000;
        wait_cyc(c + 40);

        // Asynchronous reset mid-tone, then restart from beep 1.
        c = cyc;
        req = 3'b001;
        exp_tone(c + 1, 3'b001, 2);
        zeros(c + 3, c + 5);
        exp_pat(c + 6, 3'b001, 4, 1, d);
        zeros(d + 1, d + 3);
        wait_cyc(c + 3);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({buzz, grant, busy} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset buzz/grant/busy got %b/%b/%b want 0/000/0", buzz, grant, busy);
        end
        wait_cyc(c + 5);
        rst_ni = 1'b1;
        wait_cyc(d);
        req = 3'b000;
        wait_cyc(d + 3);

        // Held request: single done, re-raise starts a new pattern.
        c = cyc;
        req = 3'b001;
        exp_pat(c + 1, 3'b001, 4, 1, d);
        exp_hold(d + 1, d + 200, 3'b001);
        zeros(d + 201, d + 203);
        exp_pat(d + 204, 3'b001, 4, 1, d2);
        zeros(d2 + 1, d2 + 3);
        wait_cyc(d + 200);
        req = 3'b000;
        wait_cyc(d + 203);
        req = 3'b001;
        wait_cyc(d2);
        req = 3'b000;
        wait_cyc(d2 + 5);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
